fir_mac_sequencer: RTL
======================

FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

Interface
REQ-001 The module SHALL have parameter NTAPS, default 16, giving the number of FIR taps (power of two, 2..64).
REQ-002 The module SHALL have parameter ACC_W, default 28, giving the accumulator and output width (24 + log2(NTAPS)).
REQ-003 The module SHALL have one clock and one reset: the reset is asynchronous and active-low.
REQ-004 ap_clk  in  1  system clock; all state updates on its rising edge.
REQ-005 ap_rst_n  in  1  asynchronous active-low reset.
REQ-006 s_valid  in  1  input sample valid.
REQ-007 s_ready  out  1  sequencer can accept a sample.
REQ-008 s_data  in  16  signed input sample.
REQ-009 coef_we  in  1  coefficient write strobe.
REQ-010 coef_addr  in  log2(NTAPS)  coefficient index k.
REQ-011 coef_data  in  8  unsigned coefficient.
REQ-012 mul_a  out  16  signed operand to the shared 16s x 8u -> 24-bit combinational multiplier.
REQ-013 mul_b  out  8  unsigned operand to the shared multiplier.
REQ-014 mul_p  in  24  signed product returned in the same cycle.
REQ-015 m_valid  out  1  filter output valid.
REQ-016 m_ready  in  1  downstream accepts output.
REQ-017 m_data  out  ACC_W  signed filter output y[n].
REQ-018 busy  out  1  high while in state MAC.

Function
REQ-019 The sequencer SHALL compute y[n] = sum over k = 0..NTAPS-1 of coef[k] * x[n-k], with products from one shared multiplier used once per cycle.
REQ-020 The FSM SHALL have states IDLE, MAC and OUT.
REQ-021 In IDLE, s_ready SHALL be 1; s_valid & s_ready SHALL write s_data into the circular delay line at wr_ptr and move the FSM to MAC with k = 0.
REQ-022 In MAC, each cycle SHALL drive mul_a = x[(wr_ptr - k) mod NTAPS], so that the newest sample is used at k = 0, and mul_b = coef[k].
REQ-023 In MAC, acc SHALL load sign_extend(mul_p) when k = 0, and otherwise load acc + sign_extend(mul_p).
REQ-024 After the k = NTAPS-1 cycle, wr_ptr SHALL increment modulo NTAPS, m_data SHALL load the final sum, and the FSM SHALL go to OUT.
REQ-025 Latency: a sample accepted in cycle t SHALL give m_valid = 1 in cycle t+1+NTAPS; throughput SHALL be one sample per NTAPS+2 cycles at most.
REQ-026 In OUT, m_valid SHALL be 1 and m_data SHALL be held stable until m_valid & m_ready, then the FSM SHALL return to IDLE.
REQ-027 s_ready SHALL be 0 in MAC and OUT; s_valid in those states SHALL be ignored and no sample SHALL be lost or duplicated.
REQ-028 mul_a and mul_b SHALL be 0 outside MAC.
REQ-029 coef_we SHALL write coef[coef_addr] in IDLE and OUT, and SHALL be dropped when busy = 1.
REQ-030 The accumulator SHALL be ACC_W bits with no saturation; the full-scale sum SHALL fit without wrap.
REQ-031 wr_ptr wrap from NTAPS-1 to 0 SHALL be seamless, with no extra cycles.

Reset
REQ-032 While ap_rst_n = 0 the following SHALL hold: state IDLE, s_ready 0, m_valid 0, m_data 0, busy 0, acc 0, wr_ptr 0, k 0, all delay-line entries 0, all coefficients 0.
REQ-033 s_ready SHALL rise to 1 on the first ap_clk edge after ap_rst_n deasserts.
REQ-034 Reset asserted mid-MAC or mid-OUT SHALL abort the computation immediately, and no m_valid SHALL follow for that sample.

Verification
REQ-035 Impulse: coef[k] = k+1, then input 1 followed by 15 zeros, with m_ready = 1 -> outputs 1,2,...,16 and then 0 for further zero inputs.
REQ-036 Full scale: all coef = 255 and 16 samples of -32768 -> 16th output = -133693440 with no wrap.
REQ-037 Latency/backpressure: sample accepted in cycle t -> m_valid in cycle t+17; m_ready held 0 for 5 cycles -> m_data stable, s_ready 0, s_valid pulses ignored.
REQ-038 Coefficient write with busy = 1 -> coef unchanged (checked via the impulse response); the same write in IDLE -> takes effect on the next sample.
REQ-039 Reset asserted at k = 7 of MAC -> m_valid never asserts; after release all outputs are at reset values and a new impulse reproduces REQ-035 from zeroed history.
REQ-040 Wrap: more than 32 consecutive samples of random data -> outputs match a reference model across two wr_ptr wraps.

Source files
------------

// File: rtl/fir_mac_sequencer_if.sv
// Bundle of sample-in, coefficient-write, shared-multiplier and result-out signals
// for the FIR MAC sequencer. The slave modport is the sequencer's view.
interface fir_mac_sequencer_if #(
   parameter int NTAPS = 16,
   parameter int ACC_W = 28
);
   localparam int AW = $clog2(NTAPS);

   logic                    s_valid;
   logic                    s_ready;
   logic signed [15:0]      s_data;
   logic                    coef_we;
   logic [AW-1:0]           coef_addr;
   logic [7:0]              coef_data;
   logic signed [15:0]      mul_a;
   logic [7:0]              mul_b;
   logic signed [23:0]      mul_p;
   logic                    m_valid;
   logic                    m_ready;
   logic signed [ACC_W-1:0] m_data;
   logic                    busy;

   modport slave (
      input  s_valid, s_data, coef_we, coef_addr, coef_data, mul_p, m_ready,
      output s_ready, mul_a, mul_b, m_valid, m_data, busy
   );

   modport master (
      output s_valid, s_data, coef_we, coef_addr, coef_data, mul_p, m_ready,
      input  s_ready, mul_a, mul_b, m_valid, m_data, busy
   );
endinterface

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one sample in, NTAPS MAC cycles through an external
// 16s x 8u multiplier, then the result is held until the consumer takes it.
module fir_mac_sequencer #(
   parameter int NTAPS = 16,
   parameter int ACC_W = 28
) (
   input  logic               ap_clk,
   input  logic               ap_rst_n,
   fir_mac_sequencer_if.slave bus
);
   localparam int AW = $clog2(NTAPS);
   localparam logic [AW-1:0] K_LAST = AW'(NTAPS - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, OUT = 2'd2} state_t;

   state_t                  state_q, state_d;
   logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]           k_q, k_d;
   logic [AW-1:0]           rd_idx;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic signed [ACC_W-1:0] m_data_q, m_data_d;
   logic signed [ACC_W-1:0] prod_ext;
   logic                    rdy_en_q;
   logic                    accept;
   logic                    coef_wr;
   logic signed [15:0]      x_q    [NTAPS];
   logic [7:0]              coef_q [NTAPS];

   // rdy_en_q keeps s_ready low until the first edge after reset release
   assign bus.s_ready = rdy_en_q && (state_q == IDLE);
   assign accept      = bus.s_valid && bus.s_ready;
   assign coef_wr     = bus.coef_we && (state_q != MAC);
   assign rd_idx      = wr_ptr_q - k_q;
   assign prod_ext    = {{(ACC_W-24){bus.mul_p[23]}}, bus.mul_p};

   assign bus.busy    = (state_q == MAC);
   assign bus.m_valid = (state_q == OUT);
   assign bus.m_data  = m_data_q;
   assign bus.mul_a   = (state_q == MAC) ? x_q[rd_idx] : 16'sd0;
   assign bus.mul_b   = (state_q == MAC) ? coef_q[k_q] : 8'd0;

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      k_d      = k_q;
      acc_d    = acc_q;
      m_data_d = m_data_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = MAC;
               k_d     = '0;
            end
         end
         MAC: begin
            acc_d = (k_q == '0) ? prod_ext : acc_q + prod_ext;
            k_d   = k_q + 1'b1;
            if (k_q == K_LAST) begin
               state_d  = OUT;
               k_d      = '0;
               wr_ptr_d = wr_ptr_q + 1'b1;
               m_data_d = acc_d;
            end
         end
         OUT: begin
            if (bus.m_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         k_q      <= '0;
         acc_q    <= '0;
         m_data_q <= '0;
         rdy_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         k_q      <= k_d;
         acc_q    <= acc_d;
         m_data_q <= m_data_d;
         rdy_en_q <= 1'b1;
      end
   end

   // Delay line and coefficient bank; coefficient writes are ignored mid-MAC
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         for (int i = 0; i < NTAPS; i++) begin
            x_q[i]    <= '0;
            coef_q[i] <= '0;
         end
      end else begin
         if (accept)  x_q[wr_ptr_q]        <= bus.s_data;
         if (coef_wr) coef_q[bus.coef_addr] <= bus.coef_data;
      end
   end
endmodule
